// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default sample widths, saturation limits and the
// width of the saturation statistics counter.
package fir_pkg;

  localparam int unsigned FIR_DATA_IN  = 32;
  localparam int unsigned FIR_DATA_OUT = 16;
  localparam int unsigned SAT_CNT_W    = 16;

  localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

  // Largest and smallest representable signed value of a given width.
  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

  localparam longint FIR_SAT_MAX = sat_max(FIR_DATA_OUT);
  localparam longint FIR_SAT_MIN = sat_min(FIR_DATA_OUT);

endpackage

// File: rtl/axis_skid_buffer.sv
// Output register plus one-entry skid register. The upstream ready is registered so that
// out_ready_i never reaches in_ready_o combinationally.
module axis_skid_buffer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  assign push = in_valid_i & ready_q;
  assign pop  = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      out_valid_d = 1'b0;
    end
    if (skid_valid_q) begin
      // ready_q is low here, so only a drain of the skid entry can happen
      if (pop) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid_q || pop) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/fir_requantizer.sv
// Rounds, saturates and decimates wide FIR output samples into a narrower AXI-Stream,
// keeping sticky saturation statistics for forwarded samples.
module fir_requantizer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_IN  = FIR_DATA_IN,
  parameter int unsigned DATA_OUT = FIR_DATA_OUT,
  parameter int unsigned SHIFT    = 15,
  parameter int unsigned DECIM    = 1
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic                 s_axis_valid,
  input  logic [DATA_IN-1:0]   s_axis_data,
  output logic                 s_axis_ready,
  output logic                 m_axis_valid,
  output logic [DATA_OUT-1:0]  m_axis_data,
  input  logic                 m_axis_ready,
  input  logic                 clear,
  output logic                 sat_flag,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam int unsigned PhaseW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(DECIM - 1);

  localparam logic signed [DATA_IN:0] RoundBias = (DATA_IN+1)'(longint'(1) << (SHIFT - 1));
  localparam logic signed [DATA_IN:0] SatHi     = (DATA_IN+1)'(sat_max(DATA_OUT));
  localparam logic signed [DATA_IN:0] SatLo     = (DATA_IN+1)'(sat_min(DATA_OUT));

  logic signed [DATA_IN:0] sum_ext, rnd;
  logic                    sat_hi, sat_lo;
  logic [DATA_OUT-1:0]     q_data;
  logic                    in_fire, fwd, fwd_valid, sat_evt;

  logic [PhaseW-1:0]    phase_q, phase_d;
  logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;
  logic                 sat_flag_q, sat_flag_d;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    sum_ext = $signed({s_axis_data[DATA_IN-1], s_axis_data}) + RoundBias;
    rnd     = sum_ext >>> SHIFT;
    sat_hi  = rnd > SatHi;
    sat_lo  = rnd < SatLo;
    if (sat_hi) begin
      q_data = SatHi[DATA_OUT-1:0];
    end else if (sat_lo) begin
      q_data = SatLo[DATA_OUT-1:0];
    end else begin
      q_data = rnd[DATA_OUT-1:0];
    end
  end

  assign in_fire   = s_axis_valid & s_axis_ready;
  assign fwd       = (phase_q == '0);
  assign fwd_valid = s_axis_valid & fwd;
  assign sat_evt   = in_fire & fwd & (sat_hi | sat_lo);

  always_comb begin
    phase_d = phase_q;
    if (in_fire) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseW'(1);
    end
  end

  // A saturation coincident with clear survives the clear.
  always_comb begin
    sat_count_d = sat_count_q;
    sat_flag_d  = sat_flag_q | sat_evt;
    if (clear) begin
      sat_count_d = SAT_CNT_W'(sat_evt);
      sat_flag_d  = sat_evt;
    end else if (sat_evt && (sat_count_q != SAT_CNT_MAX)) begin
      sat_count_d = sat_count_q + SAT_CNT_W'(1);
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      phase_q     <= '0;
      sat_count_q <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      sat_count_q <= sat_count_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  axis_skid_buffer #(
    .Width(DATA_OUT)
  ) u_skid (
    .clk_i      (axi_clk),
    .rst_ni     (axi_reset_n),
    .in_valid_i (fwd_valid),
    .in_data_i  (q_data),
    .in_ready_o (s_axis_ready),
    .out_valid_o(m_axis_valid),
    .out_data_o (m_axis_data),
    .out_ready_i(m_axis_ready)
  );

  assign sat_count = sat_count_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_fir_requantizer.sv
// Self-checking bench for fir_requantizer: one DECIM=1 instance and one DECIM=4 instance
// sharing clock and reset, checked against an arithmetic reference model.
module tb_fir_requantizer;

  logic        axi_clk_tb;
  logic        axi_reset_n_tb;

  logic        s_axis_valid, s_axis_ready, m_axis_valid, m_axis_ready, clear, sat_flag;
  logic [31:0] s_axis_data;
  logic [15:0] m_axis_data, sat_count;

  logic        d_s_axis_valid, d_s_axis_ready, d_m_axis_valid, d_m_axis_ready, d_clear, d_sat_flag;
  logic [31:0] d_s_axis_data;
  logic [15:0] d_m_axis_data, d_sat_count;

  int total;
  int bad;

  fir_requantizer #(
    .DATA_IN(32), .DATA_OUT(16), .SHIFT(15), .DECIM(1)
  ) dut (
    .axi_clk     (axi_clk_tb),
    .axi_reset_n (axi_reset_n_tb),
    .s_axis_valid(s_axis_valid),
    .s_axis_data (s_axis_data),
    .s_axis_ready(s_axis_ready),
    .m_axis_valid(m_axis_valid),
    .m_axis_data (m_axis_data),
    .m_axis_ready(m_axis_ready),
    .clear       (clear),
    .sat_flag    (sat_flag),
    .sat_count   (sat_count)
  );

  fir_requantizer #(
    .DATA_IN(32), .DATA_OUT(16), .SHIFT(15), .DECIM(4)
  ) dut_dec (
    .axi_clk     (axi_clk_tb),
    .axi_reset_n (axi_reset_n_tb),
    .s_axis_valid(d_s_axis_valid),
    .s_axis_data (d_s_axis_data),
    .s_axis_ready(d_s_axis_ready),
    .m_axis_valid(d_m_axis_valid),
    .m_axis_data (d_m_axis_data),
    .m_axis_ready(d_m_axis_ready),
    .clear       (d_clear),
    .sat_flag    (d_sat_flag),
    .sat_count   (d_sat_count)
  );

  initial axi_clk_tb = 1'b0;
  always #5 axi_clk_tb = ~axi_clk_tb;

  // Reference: floor((x + 2^14) / 2^15), clamped to the signed 16-bit range.
  function automatic longint model_requant(input logic [31:0] x);
    longint v, r;
    v = longint'($signed(x)) + 64'sd16384;
    r = v / 32768;
    if ((v % 32768) != 0 && v < 0) r = r - 1;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic bit model_sat(input logic [31:0] x);
    longint v, r;
    v = longint'($signed(x)) + 64'sd16384;
    r = v / 32768;
    if ((v % 32768) != 0 && v < 0) r = r - 1;
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge axi_clk_tb);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    axi_reset_n_tb = 1'b0;
    repeat (2) @(negedge axi_clk_tb);
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_axis_valid); end
    total++; if (m_axis_data !== 16'h0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_axis_data); end
    total++; if (s_axis_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_axis_ready); end
    total++; if (sat_count !== 16'h0) begin bad++; $display("FAIL rst_sat_count: got %h want 0", sat_count); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
    total++; if (d_m_axis_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid: got %b want 0", d_m_axis_valid); end
    axi_reset_n_tb = 1'b1;
    #1;
    total++; if (s_axis_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_early: got %b want 0", s_axis_ready); end
    @(negedge axi_clk_tb);
    total++; if (s_axis_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %b want 1", s_axis_ready); end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [3];
    longint      want [3];
    vin  = '{32'h0000_4000, 32'hFFFF_C000, 32'hFFFF_BFFF};
    want = '{64'sd1, 64'sd0, -64'sd1};
    m_axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_axis_valid = 1'b1;
      s_axis_data  = vin[i];
      total++; if (s_axis_ready !== 1'b1) begin bad++; $display("FAIL round_ready[%0d]: got %b want 1", i, s_axis_ready); end
      @(negedge axi_clk_tb);
      total++; if (m_axis_valid !== 1'b1) begin bad++; $display("FAIL round_valid[%0d]: got %b want 1", i, m_axis_valid); end
      total++;
      if (longint'($signed(m_axis_data)) !== want[i]) begin
        bad++; $display("FAIL round_data[%0d]: got %0d want %0d", i, $signed(m_axis_data), want[i]);
      end
    end
    s_axis_valid = 1'b0;
    @(negedge axi_clk_tb);
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL round_drain: got %b want 0", m_axis_valid); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL round_sat_flag: got %b want 0", sat_flag); end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [4];
    longint      want [4];
    vin  = '{32'h3FFF_8000, 32'h4000_0000, 32'hC000_0000, 32'hBFFF_0000};
    want = '{64'sd32767, 64'sd32767, -64'sd32768, -64'sd32768};
    pulse_clear();
    m_axis_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis_valid = 1'b1;
      s_axis_data  = vin[i];
      @(negedge axi_clk_tb);
      total++;
      if (longint'($signed(m_axis_data)) !== want[i] || m_axis_valid !== 1'b1) begin
        bad++; $display("FAIL sat_data[%0d]: got %0d (valid %b) want %0d", i, $signed(m_axis_data), m_axis_valid, want[i]);
      end
    end
    s_axis_valid = 1'b0;
    total++; if (sat_count !== 16'd2) begin bad++; $display("FAIL sat_count: got %0d want 2", sat_count); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
    pulse_clear();
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL sat_clear_count: got %0d want 0", sat_count); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear_flag: got %b want 0", sat_flag); end
  endtask

  task automatic test_backpressure();
    longint      exp_q [$];
    int          sent, recv, occ;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic [31:0] cur;
    sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0;
    cur  = 32'((sent - 50) * 32768 + int'($urandom_range(0, 32767)));
    for (int cyc = 0; cyc < 3000 && recv < 100; cyc++) begin
      occ = exp_q.size();
      total++; if (s_axis_ready !== (occ < 2)) begin bad++; $display("FAIL bp_ready c%0d: got %b want %b", cyc, s_axis_ready, occ < 2); end
      total++; if (m_axis_valid !== (occ > 0)) begin bad++; $display("FAIL bp_valid c%0d: got %b want %b", cyc, m_axis_valid, occ > 0); end
      if (prev_stall) begin
        total++;
        if (m_axis_valid !== 1'b1 || m_axis_data !== prev_data) begin
          bad++; $display("FAIL bp_stall c%0d: got %h want %h", cyc, m_axis_data, prev_data);
        end
      end
      s_axis_valid = (sent < 100);
      s_axis_data  = cur;
      m_axis_ready = 1'($urandom_range(0, 1));
      if (m_axis_valid && m_axis_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra c%0d: got %0d want none", cyc, $signed(m_axis_data));
        end else begin
          if (longint'($signed(m_axis_data)) !== exp_q[0]) begin
            bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", recv, $signed(m_axis_data), exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        recv++;
      end
      if (s_axis_valid && s_axis_ready) begin
        exp_q.push_back(model_requant(cur));
        sent++;
        cur = 32'((sent - 50) * 32768 + int'($urandom_range(0, 32767)));
      end
      prev_stall = m_axis_valid && !m_axis_ready;
      prev_data  = m_axis_data;
      @(negedge axi_clk_tb);
    end
    s_axis_valid = 1'b0;
    m_axis_ready = 1'b1;
    total++; if (sent !== 100) begin bad++; $display("FAIL bp_sent: got %0d want 100", sent); end
    total++; if (recv !== 100) begin bad++; $display("FAIL bp_recv: got %0d want 100", recv); end
    repeat (2) @(negedge axi_clk_tb);
  endtask

  task automatic test_decimation();
    longint exp_q [$];
    logic [31:0] vin [20];
    int in_x, out_x;
    for (int k = 0; k < 16; k++) vin[k] = 32'(k * 32768);
    vin[16] = 32'h0; vin[17] = 32'h7FFF_FFFF; vin[18] = 32'h7FFF_FFFF; vin[19] = 32'h8000_0000;
    in_x = 0; out_x = 0;
    d_m_axis_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (in_x < 20 || exp_q.size() != 0); cyc++) begin
      d_s_axis_valid = (in_x < 20);
      d_s_axis_data  = (in_x < 20) ? vin[in_x] : 32'h0;
      if (d_m_axis_valid && d_m_axis_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL dec_extra: got %0d want none", $signed(d_m_axis_data));
        end else begin
          if (longint'($signed(d_m_axis_data)) !== exp_q[0]) begin
            bad++; $display("FAIL dec_data[%0d]: got %0d want %0d", out_x, $signed(d_m_axis_data), exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        out_x++;
      end
      if (d_s_axis_valid && d_s_axis_ready) begin
        if (in_x % 4 == 0) exp_q.push_back(model_requant(vin[in_x]));
        in_x++;
        if (in_x == 16) begin
          total++; if (out_x > 4) begin bad++; $display("FAIL dec_outs16: got %0d want <=4", out_x); end
        end
      end
      @(negedge axi_clk_tb);
    end
    d_s_axis_valid = 1'b0;
    total++; if (in_x !== 20) begin bad++; $display("FAIL dec_in_count: got %0d want 20", in_x); end
    total++; if (out_x !== 5) begin bad++; $display("FAIL dec_out_count: got %0d want 5", out_x); end
    total++; if (d_sat_count !== 16'd0) begin bad++; $display("FAIL dec_discard_sat: got %0d want 0", d_sat_count); end
    total++; if (d_sat_flag !== 1'b0) begin bad++; $display("FAIL dec_discard_flag: got %b want 0", d_sat_flag); end
  endtask

  task automatic test_clear_coincident();
    pulse_clear();
    m_axis_ready = 1'b1;
    s_axis_valid = 1'b1;
    s_axis_data  = 32'h7FFF_FFFF;
    @(negedge axi_clk_tb);
    s_axis_data  = 32'h8000_0000;
    @(negedge axi_clk_tb);
    total++; if (sat_count !== 16'd2) begin bad++; $display("FAIL cc_pre: got %0d want 2", sat_count); end
    s_axis_data = 32'h7FFF_FFFF;
    clear = 1'b1;
    @(negedge axi_clk_tb);
    total++; if (sat_count !== 16'd1) begin bad++; $display("FAIL cc_count: got %0d want 1", sat_count); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL cc_flag: got %b want 1", sat_flag); end
    s_axis_data = 32'h0000_1234;
    @(negedge axi_clk_tb);
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL cc_plain_count: got %0d want 0", sat_count); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL cc_plain_flag: got %b want 0", sat_flag); end
    clear = 1'b0;
    s_axis_valid = 1'b0;
    repeat (2) @(negedge axi_clk_tb);
  endtask

  task automatic test_ceiling();
    int          acc;
    logic        took;
    logic [15:0] want;
    acc = 0;
    pulse_clear();
    m_axis_ready = 1'b1;
    s_axis_valid = 1'b1;
    for (int cyc = 0; cyc < 70000 && acc < 65540; cyc++) begin
      s_axis_data = acc[0] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      took = s_axis_ready;
      if (took) acc++;
      @(negedge axi_clk_tb);
      if (took && (acc == 3 || acc == 65534 || acc == 65535 || acc == 65540)) begin
        want = (acc >= 65535) ? 16'hFFFF : 16'(acc);
        total++; if (sat_count !== want) begin bad++; $display("FAIL ceil_count@%0d: got %0d want %0d", acc, sat_count, want); end
      end
    end
    s_axis_valid = 1'b0;
    total++; if (acc !== 65540) begin bad++; $display("FAIL ceil_accepted: got %0d want 65540", acc); end
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL ceil_flag: got %b want 1", sat_flag); end
    repeat (2) @(negedge axi_clk_tb);
  endtask

  task automatic test_reset_midstream();
    int fed, outs;
    longint first;
    m_axis_ready   = 1'b0;
    d_m_axis_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_valid   = (i < 2);
      s_axis_data    = 32'((i + 5) * 32768);
      d_s_axis_valid = 1'b1;
      d_s_axis_data  = 32'(i * 32768);
      @(negedge axi_clk_tb);
    end
    s_axis_valid   = 1'b0;
    d_s_axis_valid = 1'b0;
    total++; if (s_axis_ready !== 1'b0 || m_axis_valid !== 1'b1) begin
      bad++; $display("FAIL mid_full: got ready %b valid %b want 0 1", s_axis_ready, m_axis_valid); end
    total++; if (d_s_axis_ready !== 1'b0 || d_m_axis_valid !== 1'b1) begin
      bad++; $display("FAIL mid_dec_full: got ready %b valid %b want 0 1", d_s_axis_ready, d_m_axis_valid); end
    #2 axi_reset_n_tb = 1'b0;
    #1;
    total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", m_axis_valid); end
    total++; if (d_m_axis_valid !== 1'b0) begin bad++; $display("FAIL mid_dec_valid: got %b want 0", d_m_axis_valid); end
    total++; if (m_axis_data !== 16'h0) begin bad++; $display("FAIL mid_data: got %h want 0", m_axis_data); end
    @(negedge axi_clk_tb);
    axi_reset_n_tb = 1'b1;
    m_axis_ready   = 1'b1;
    d_m_axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk_tb);
      total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b want 0", i, m_axis_valid); end
    end
    fed = 0; outs = 0; first = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      d_s_axis_valid = (fed < 4);
      d_s_axis_data  = 32'((fed + 1) * 32768);
      if (d_m_axis_valid && d_m_axis_ready) begin
        if (outs == 0) first = longint'($signed(d_m_axis_data));
        outs++;
      end
      if (d_s_axis_valid && d_s_axis_ready) fed++;
      @(negedge axi_clk_tb);
    end
    d_s_axis_valid = 1'b0;
    total++; if (outs !== 1) begin bad++; $display("FAIL mid_phase_outs: got %0d want 1", outs); end
    total++; if (first !== 64'sd1) begin bad++; $display("FAIL mid_phase_first: got %0d want 1", first); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    axi_reset_n_tb = 1'b0;
    s_axis_valid = 1'b0; s_axis_data = '0; m_axis_ready = 1'b1; clear = 1'b0;
    d_s_axis_valid = 1'b0; d_s_axis_data = '0; d_m_axis_ready = 1'b1; d_clear = 1'b0;
    @(negedge axi_clk_tb);
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_decimation();
    test_clear_coincident();
    test_ceiling();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
